// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, exception codes
// and the low-address alignment mask per access size.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RSP} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  typedef enum logic [2:0] {
    NONE, LD_MISALIGN, ST_MISALIGN, LD_FAULT, ST_FAULT, TIMEOUT, ILLEGAL_SIZE
  } lsu_exc_e;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(lsu_size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/mask placement onto the bus word, and load
// extraction from the bus word with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = $clog2(DW / 8)
) (
  input  lsu_size_e         st_size,
  input  logic [LW-1:0]     st_lane,
  input  logic [DW-1:0]     st_data,
  output logic [DW-1:0]     st_wdata,
  output logic [DW/8-1:0]   st_wmask,
  input  lsu_size_e         ld_size,
  input  logic [LW-1:0]     ld_lane,
  input  logic              ld_unsigned,
  input  logic [DW-1:0]     ld_rdata,
  output logic [DW-1:0]     ld_data
);

  localparam int NB = DW / 8;

  logic [DW-1:0] size_mask;
  logic [NB-1:0] byte_mask;
  logic [DW-1:0] ld_shifted;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    size_mask = '1;
    byte_mask = '1;
    case (st_size)
      SZ_B: begin size_mask = DW'(8'hFF);         byte_mask = NB'(4'h1); end
      SZ_H: begin size_mask = DW'(16'hFFFF);      byte_mask = NB'(4'h3); end
      SZ_W: begin size_mask = DW'(32'hFFFF_FFFF); byte_mask = NB'(4'hF); end
      default: ;
    endcase
  end

  assign st_wdata   = (st_data & size_mask) << {st_lane, 3'b000};
  assign st_wmask   = byte_mask << st_lane;
  assign ld_shifted = ld_rdata >> {ld_lane, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (ld_size)
      SZ_B: if (ld_unsigned) ld_data = DW'(ld_shifted[7:0]);
            else             ld_data = DW'($signed(ld_shifted[7:0]));
      SZ_H: if (ld_unsigned) ld_data = DW'(ld_shifted[15:0]);
            else             ld_data = DW'($signed(ld_shifted[15:0]));
      SZ_W: if (ld_unsigned) ld_data = DW'(ld_shifted[31:0]);
            else             ld_data = DW'($signed(ld_shifted[31:0]));
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// MEM-stage load/store unit: one outstanding VRB access with alignment checks,
// lane steering, load extension, and bus-error / timeout exceptions.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_load,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DW-1:0]     i_req_base,
  input  logic [DW-1:0]     i_req_imm,
  input  logic [DW-1:0]     i_req_wdata,
  output logic              o_vrb_cmd_valid,
  input  logic              i_vrb_cmd_ready,
  output logic [AW-1:0]     o_vrb_cmd_addr,
  output logic              o_vrb_cmd_read,
  output logic [DW-1:0]     o_vrb_cmd_wdata,
  output logic [DW/8-1:0]   o_vrb_cmd_wmask,
  input  logic              i_vrb_rsp_valid,
  input  logic              i_vrb_rsp_err,
  input  logic [DW-1:0]     i_vrb_rsp_rdata,
  output logic              o_write_en,
  output logic [DW-1:0]     o_write_data,
  output logic              o_done,
  output logic              o_exc_valid,
  output logic [2:0]        o_exc_cause,
  output logic [AW-1:0]     o_exc_addr,
  output logic              o_holding
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_e    state;
  logic [TW-1:0] timer;
  lsu_size_e     req_size;
  lsu_size_e     acc_size;
  logic          acc_unsigned;
  logic [DW-1:0] eff_sum;
  logic [AW-1:0] req_addr;
  logic          size_illegal;
  logic          misalign;
  logic [DW-1:0] st_wdata;
  logic [NB-1:0] st_wmask;
  logic [DW-1:0] ld_data;

  assign req_size     = lsu_size_e'(i_req_size);
  assign eff_sum      = i_req_base + i_req_imm;
  assign req_addr     = AW'(eff_sum);
  assign size_illegal = (req_size == SZ_D) && (DW == 32);
  assign misalign     = (req_addr[2:0] & align_mask(req_size)) != 3'b000;

  // Store side is steered from the live request; load side from the latched access.
  lsu_lane_align #(.DW(DW), .LW(LW)) u_align (
    .st_size     (req_size),
    .st_lane     (req_addr[LW-1:0]),
    .st_data     (i_req_wdata),
    .st_wdata    (st_wdata),
    .st_wmask    (st_wmask),
    .ld_size     (acc_size),
    .ld_lane     (o_vrb_cmd_addr[LW-1:0]),
    .ld_unsigned (acc_unsigned),
    .ld_rdata    (i_vrb_rsp_rdata),
    .ld_data     (ld_data)
  );

  // Decoded straight from state so the async reset drops cmd_valid immediately.
  assign o_req_ready     = (state == IDLE);
  assign o_vrb_cmd_valid = (state == CMD);
  assign o_holding       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      acc_size        <= SZ_B;
      acc_unsigned    <= 1'b0;
      o_vrb_cmd_addr  <= '0;
      o_vrb_cmd_read  <= 1'b0;
      o_vrb_cmd_wdata <= '0;
      o_vrb_cmd_wmask <= '0;
      o_write_en      <= 1'b0;
      o_write_data    <= '0;
      o_done          <= 1'b0;
      o_exc_valid     <= 1'b0;
      o_exc_cause     <= NONE;
      o_exc_addr      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      o_write_en   <= 1'b0;
      o_write_data <= '0;
      o_done       <= 1'b0;
      o_exc_valid  <= 1'b0;
      o_exc_cause  <= NONE;
      o_exc_addr   <= '0;
      case (state)
        IDLE: if (i_req_valid) begin
          if (size_illegal) begin
            o_exc_valid <= 1'b1;
            o_exc_cause <= ILLEGAL_SIZE;
            o_exc_addr  <= req_addr;
          end else if (misalign) begin
            o_exc_valid <= 1'b1;
            o_exc_cause <= i_req_load ? LD_MISALIGN : ST_MISALIGN;
            o_exc_addr  <= req_addr;
          end else begin
            o_vrb_cmd_addr  <= req_addr;
            o_vrb_cmd_read  <= i_req_load;
            o_vrb_cmd_wdata <= st_wdata;
            o_vrb_cmd_wmask <= st_wmask;
            acc_size        <= req_size;
            acc_unsigned    <= i_req_unsigned;
            state           <= CMD;
          end
        end
        CMD: if (i_vrb_cmd_ready) begin
          state <= RSP;
          timer <= '0;
        end
        RSP: begin
          if (i_vrb_rsp_valid) begin
            state <= IDLE;
            if (i_vrb_rsp_err) begin
              o_exc_valid <= 1'b1;
              o_exc_cause <= o_vrb_cmd_read ? LD_FAULT : ST_FAULT;
              o_exc_addr  <= o_vrb_cmd_addr;
            end else if (o_vrb_cmd_read) begin
              o_write_en   <= 1'b1;
              o_write_data <= ld_data;
            end else begin
              o_done <= 1'b1;
            end
          end else if (TIMEOUT_CYC != 0 && timer == T_LAST) begin
            state       <= IDLE;
            o_exc_valid <= 1'b1;
            o_exc_cause <= TIMEOUT;
            o_exc_addr  <= o_vrb_cmd_addr;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response while the command is still pending breaks the VRB protocol.
  rsp_in_cmd: assert property (@(posedge clk) disable iff (!rst_n)
                               !(state == CMD && i_vrb_rsp_valid));

endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: a 32-bit instance (short watchdog) and a 64-bit
// instance share stimulus; a monitor pops expected commands/results as they appear.
module tb_lsu_pipe;
  import lsu_pkg::*;

  localparam int T0_TIMEOUT = 4;
  localparam int K_WR = 0, K_DONE = 1, K_EXC = 2;

  typedef struct {
    int          dut;
    int          kind;
    logic [63:0] data;
    logic [2:0]  cause;
    logic [31:0] addr;
  } res_t;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic        rd;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } cmd_t;

  res_t res_q[$];
  cmd_t cmd_q[$];

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   last_res_cyc;

  logic        req_valid [2];
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic        req_load, req_unsigned, rsp_err;
  logic [1:0]  req_size;
  logic [63:0] req_base, req_imm, req_wdata, rsp_rdata;

  logic        ready [2], holding [2], cmd_v [2], cmd_rd [2];
  logic        w_en [2], done [2], exc_v [2];
  logic [2:0]  exc_c [2];
  logic [31:0] exc_a [2], cmd_a [2];
  logic [63:0] w_data [2], cmd_wd [2];
  logic [7:0]  cmd_wm [2];
  logic [31:0] w_data32, cmd_wd32;
  logic [3:0]  cmd_wm32;

  assign w_data[0] = {32'd0, w_data32};
  assign cmd_wd[0] = {32'd0, cmd_wd32};
  assign cmd_wm[0] = {4'd0, cmd_wm32};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_pipe #(.AW(32), .DW(32), .TIMEOUT_CYC(T0_TIMEOUT)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(ready[0]),
    .i_req_load(req_load), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_base(req_base[31:0]), .i_req_imm(req_imm[31:0]), .i_req_wdata(req_wdata[31:0]),
    .o_vrb_cmd_valid(cmd_v[0]), .i_vrb_cmd_ready(cmd_ready[0]),
    .o_vrb_cmd_addr(cmd_a[0]), .o_vrb_cmd_read(cmd_rd[0]),
    .o_vrb_cmd_wdata(cmd_wd32), .o_vrb_cmd_wmask(cmd_wm32),
    .i_vrb_rsp_valid(rsp_valid[0]), .i_vrb_rsp_err(rsp_err), .i_vrb_rsp_rdata(rsp_rdata[31:0]),
    .o_write_en(w_en[0]), .o_write_data(w_data32), .o_done(done[0]),
    .o_exc_valid(exc_v[0]), .o_exc_cause(exc_c[0]), .o_exc_addr(exc_a[0]),
    .o_holding(holding[0])
  );

  lsu_pipe #(.AW(32), .DW(64), .TIMEOUT_CYC(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(ready[1]),
    .i_req_load(req_load), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_base(req_base), .i_req_imm(req_imm), .i_req_wdata(req_wdata),
    .o_vrb_cmd_valid(cmd_v[1]), .i_vrb_cmd_ready(cmd_ready[1]),
    .o_vrb_cmd_addr(cmd_a[1]), .o_vrb_cmd_read(cmd_rd[1]),
    .o_vrb_cmd_wdata(cmd_wd[1]), .o_vrb_cmd_wmask(cmd_wm[1]),
    .i_vrb_rsp_valid(rsp_valid[1]), .i_vrb_rsp_err(rsp_err), .i_vrb_rsp_rdata(rsp_rdata),
    .o_write_en(w_en[1]), .o_write_data(w_data[1]), .o_done(done[1]),
    .o_exc_valid(exc_v[1]), .o_exc_cause(exc_c[1]), .o_exc_addr(exc_a[1]),
    .o_holding(holding[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_cmd(input int d, input logic [31:0] a, input logic rd,
                         input logic [63:0] wd, input logic [7:0] wm);
    cmd_t c;
    c.dut = d; c.addr = a; c.rd = rd; c.wdata = wd; c.wmask = wm;
    cmd_q.push_back(c);
  endtask

  task automatic exp_res(input int d, input int kind, input logic [63:0] data,
                         input logic [2:0] cause, input logic [31:0] addr);
    res_t r;
    r.dut = d; r.kind = kind; r.data = data; r.cause = cause; r.addr = addr;
    res_q.push_back(r);
  endtask

  // Monitor: compares every command handshake and every result pulse with the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (w_en[d] || done[d] || exc_v[d]) begin
          last_res_cyc = cyc;
          if (res_q.size() == 0) begin
            check("unexpected_result", {61'd0, w_en[d], done[d], exc_v[d]}, 64'd0);
          end else begin
            res_t r;
            logic [2:0] oh;
            r  = res_q.pop_front();
            oh = (r.kind == K_WR) ? 3'b100 : (r.kind == K_DONE) ? 3'b010 : 3'b001;
            check("result_dut", 64'(d), 64'(r.dut));
            check("result_kind", {61'd0, w_en[d], done[d], exc_v[d]}, {61'd0, oh});
            if (r.kind == K_WR) check("write_data", w_data[d], r.data);
            if (r.kind == K_EXC) begin
              check("exc_cause", {61'd0, exc_c[d]}, {61'd0, r.cause});
              check("exc_addr", {32'd0, exc_a[d]}, {32'd0, r.addr});
            end
          end
        end
        if (!w_en[d] && w_data[d] != 64'd0) check("write_data_idle", w_data[d], 64'd0);
        if (cmd_v[d] && cmd_ready[d]) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_cmd", 64'd1, 64'd0);
          end else begin
            cmd_t c;
            c = cmd_q.pop_front();
            check("cmd_dut", 64'(d), 64'(c.dut));
            check("cmd_addr", {32'd0, cmd_a[d]}, {32'd0, c.addr});
            check("cmd_read", {63'd0, cmd_rd[d]}, {63'd0, c.rd});
            check("cmd_wmask", {56'd0, cmd_wm[d]}, {56'd0, c.wmask});
            if (!c.rd) check("cmd_wdata", cmd_wd[d], c.wdata);
          end
        end
      end
    end
  end

  // One access: request, optional stalled command phase, response after rsp_dly
  // cycles (negative = never), then wait for the result and check its cycle.
  task automatic run(input int d, input logic ld, input logic [1:0] sz, input logic uns,
                     input logic [63:0] base, input logic [63:0] imm, input logic [63:0] wdata,
                     input logic with_cmd, input int stall, input int rsp_dly,
                     input logic [63:0] rdata, input logic err);
    int acc, hs, exp_c;
    @(posedge clk); #1;
    req_load = ld; req_size = sz; req_unsigned = uns;
    req_base = base; req_imm = imm; req_wdata = wdata;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    acc   = cyc;
    exp_c = acc;
    if (with_cmd) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("holding_stall", {63'd0, holding[d]}, 64'd1);
        check("cmd_valid_stall", {63'd0, cmd_v[d]}, 64'd1);
        check("cmd_addr_stable", {32'd0, cmd_a[d]}, {32'd0, cmd_q[0].addr});
        check("cmd_wmask_stable", {56'd0, cmd_wm[d]}, {56'd0, cmd_q[0].wmask});
        if (!cmd_q[0].rd) check("cmd_wdata_stable", cmd_wd[d], cmd_q[0].wdata);
      end
      @(negedge clk);
      cmd_ready[d] = 1'b1;
      @(posedge clk); #1;
      cmd_ready[d] = 1'b0;
      hs = cyc;
      if (rsp_dly < 0) begin
        exp_c = hs + T0_TIMEOUT;
      end else begin
        repeat (rsp_dly) @(posedge clk);
        #1;
        rsp_valid[d] = 1'b1; rsp_rdata = rdata; rsp_err = err;
        @(posedge clk); #1;
        rsp_valid[d] = 1'b0; rsp_err = 1'b0;
        exp_c = cyc;
      end
    end
    for (int i = 0; i < 40 && res_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("result_arrived", 64'(res_q.size()), 64'd0);
    check("cmd_consumed", 64'(cmd_q.size()), 64'd0);
    check("result_cycle", 64'(last_res_cyc), 64'(exp_c));
    check("ready_after", {63'd0, ready[d]}, 64'd1);
    res_q.delete();
    cmd_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; last_res_cyc = -1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; cmd_ready[d] = 1'b0; rsp_valid[d] = 1'b0;
    end
    req_load = 1'b0; req_unsigned = 1'b0; rsp_err = 1'b0; req_size = 2'd0;
    req_base = '0; req_imm = '0; req_wdata = '0; rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", {63'd0, ready[d]}, 64'd1);
      check("rst_holding", {63'd0, holding[d]}, 64'd0);
      check("rst_cmd_valid", {63'd0, cmd_v[d]}, 64'd0);
      check("rst_write_en", {63'd0, w_en[d]}, 64'd0);
      check("rst_done", {63'd0, done[d]}, 64'd0);
      check("rst_exc_valid", {63'd0, exc_v[d]}, 64'd0);
      check("rst_write_data", w_data[d], 64'd0);
    end

    // ---- 32-bit instance ----
    exp_cmd(0, 32'h100, 1'b0, 64'hDEADBEEF, 8'hF);
    exp_res(0, K_DONE, 0, NONE, 0);
    run(0, 1'b0, 2'd2, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF, 1'b1, 0, 1, 0, 1'b0);

    exp_cmd(0, 32'h103, 1'b0, 64'hA500_0000, 8'h8);
    exp_res(0, K_DONE, 0, NONE, 0);
    run(0, 1'b0, 2'd0, 1'b0, 64'h103, 64'h0, 64'h1234_56A5, 1'b1, 0, 0, 0, 1'b0);

    exp_cmd(0, 32'h103, 1'b1, 0, 8'h8);
    exp_res(0, K_WR, 64'hFFFF_FF80, NONE, 0);
    run(0, 1'b1, 2'd0, 1'b0, 64'h103, 64'h0, 64'h0, 1'b1, 0, 1, 64'h8000_0000, 1'b0);

    exp_cmd(0, 32'h103, 1'b1, 0, 8'h8);
    exp_res(0, K_WR, 64'h80, NONE, 0);
    run(0, 1'b1, 2'd0, 1'b1, 64'h103, 64'h0, 64'h0, 1'b1, 0, 1, 64'h8000_0000, 1'b0);

    exp_res(0, K_EXC, 0, LD_MISALIGN, 32'h101);
    run(0, 1'b1, 2'd1, 1'b0, 64'h100, 64'h1, 64'h0, 1'b0, 0, 0, 0, 1'b0);

    exp_cmd(0, 32'h1FC, 1'b0, 64'h1122_3344, 8'hF);
    exp_res(0, K_EXC, 0, ST_FAULT, 32'h1FC);
    run(0, 1'b0, 2'd2, 1'b0, 64'h200, 64'hFFFF_FFFC, 64'h1122_3344, 1'b1, 5, 1, 0, 1'b1);

    exp_cmd(0, 32'h102, 1'b1, 0, 8'hC);
    exp_res(0, K_WR, 64'hFFFF_8001, NONE, 0);
    run(0, 1'b1, 2'd1, 1'b0, 64'h102, 64'h0, 64'h0, 1'b1, 0, 2, 64'h8001_1234, 1'b0);

    exp_cmd(0, 32'h102, 1'b0, 64'hBEEF_0000, 8'hC);
    exp_res(0, K_DONE, 0, NONE, 0);
    run(0, 1'b0, 2'd1, 1'b0, 64'h102, 64'h0, 64'hFFFF_BEEF, 1'b1, 1, 0, 0, 1'b0);

    exp_res(0, K_EXC, 0, ILLEGAL_SIZE, 32'h101);
    run(0, 1'b0, 2'd3, 1'b0, 64'h101, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1'b0);

    exp_res(0, K_EXC, 0, ST_MISALIGN, 32'h102);
    run(0, 1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1'b0);

    exp_cmd(0, 32'h104, 1'b1, 0, 8'hF);
    exp_res(0, K_EXC, 0, LD_FAULT, 32'h104);
    run(0, 1'b1, 2'd2, 1'b0, 64'h104, 64'h0, 64'h0, 1'b1, 0, 0, 0, 1'b1);

    exp_cmd(0, 32'h4, 1'b1, 0, 8'hF);
    exp_res(0, K_WR, 64'hCAFE_F00D, NONE, 0);
    run(0, 1'b1, 2'd2, 1'b0, 64'hFFFF_FFFC, 64'h8, 64'h0, 1'b1, 0, 1, 64'hCAFE_F00D, 1'b0);

    exp_cmd(0, 32'h40, 1'b1, 0, 8'hF);
    exp_res(0, K_EXC, 0, TIMEOUT, 32'h40);
    run(0, 1'b1, 2'd2, 1'b0, 64'h40, 64'h0, 64'h0, 1'b1, 0, -1, 0, 1'b0);

    // Late response after the timeout must be dropped silently.
    @(posedge clk); #1;
    rsp_valid[0] = 1'b1; rsp_rdata = 64'h1234_5678;
    @(posedge clk); #1;
    rsp_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("late_rsp_holding", {63'd0, holding[0]}, 64'd0);

    exp_cmd(0, 32'h41, 1'b1, 0, 8'h2);
    exp_res(0, K_WR, 64'hAB, NONE, 0);
    run(0, 1'b1, 2'd0, 1'b1, 64'h41, 64'h0, 64'h0, 1'b1, 0, 0, 64'h0000_AB00, 1'b0);

    // ---- 64-bit instance ----
    exp_cmd(1, 32'h8, 1'b1, 0, 8'hFF);
    exp_res(1, K_WR, 64'h0123_4567_89AB_CDEF, NONE, 0);
    run(1, 1'b1, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0, 1'b1, 0, 1, 64'h0123_4567_89AB_CDEF, 1'b0);

    exp_cmd(1, 32'hC, 1'b1, 0, 8'hF0);
    exp_res(1, K_WR, 64'h0000_0000_F000_0000, NONE, 0);
    run(1, 1'b1, 2'd2, 1'b1, 64'hC, 64'h0, 64'h0, 1'b1, 0, 1, 64'hF000_0000_0000_0000, 1'b0);

    exp_cmd(1, 32'hC, 1'b1, 0, 8'hF0);
    exp_res(1, K_WR, 64'hFFFF_FFFF_F000_0000, NONE, 0);
    run(1, 1'b1, 2'd2, 1'b0, 64'h4, 64'h8, 64'h0, 1'b1, 0, 0, 64'hF000_0000_0000_0000, 1'b0);

    exp_cmd(1, 32'hC, 1'b0, 64'h1122_3344_0000_0000, 8'hF0);
    exp_res(1, K_DONE, 0, NONE, 0);
    run(1, 1'b0, 2'd2, 1'b0, 64'hC, 64'h0, 64'hAAAA_AAAA_1122_3344, 1'b1, 2, 1, 0, 1'b0);

    exp_res(1, K_EXC, 0, ST_MISALIGN, 32'h4);
    run(1, 1'b0, 2'd3, 1'b0, 64'h4, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1'b0);

    exp_cmd(1, 32'h7, 1'b0, 64'hFF00_0000_0000_0000, 8'h80);
    exp_res(1, K_DONE, 0, NONE, 0);
    run(1, 1'b0, 2'd0, 1'b0, 64'h7, 64'h0, 64'h0000_0000_0000_00FF, 1'b1, 0, 0, 0, 1'b0);

    // ---- reset in the middle of a stalled command ----
    @(posedge clk); #1;
    req_load = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_base = 64'h300; req_imm = 64'h0;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_cmd_valid_before", {63'd0, cmd_v[0]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cmd_valid_async", {63'd0, cmd_v[0]}, 64'd0);
    check("abort_holding", {63'd0, holding[0]}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    exp_cmd(0, 32'h8, 1'b1, 0, 8'hF);
    exp_res(0, K_WR, 64'h55, NONE, 0);
    run(0, 1'b1, 2'd2, 1'b0, 64'h8, 64'h0, 64'h0, 1'b1, 0, 0, 64'h55, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
